conv1d_mac_pipe: RTL and testbench

- Parametrised successor CFU conv1d dot-product engine for the int8 1D-conv kernel.
- Holds one kernel window of int8 inputs and int8 weights in local buffers.
- Computes acc = bias + sum(w[i] * (x[(i + start_filter_x*depth) mod N] + input_offset)), where N = kernel_len*input_depth.
- Generalises the fixed 8-tap/8-lane engine:
  - lane count, kernel length and channel count are parametrised or runtime-set;
  - adds bias preload, partial-group lane masking, a registered product pipeline, packed 4-byte writes, and status/error reporting.

---
 rtl/conv1d_mac_pipe.sv | 203 ++++++++++++++++++++
 tb/tb_conv1d_mac_pipe.sv | 410 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/conv1d_mac_pipe.sv
// conv1d_mac_pipe: int8 1D-conv dot-product engine with
// LANES MACs per cycle over a runtime-sized kernel window.
module conv1d_mac_pipe #(
  parameter int LANES      = 8,
  parameter int MAX_KERNEL = 8,
  parameter int MAX_CH     = 128,
  parameter int ACC_WIDTH  = 32,
  parameter int BUF_DEPTH  = MAX_KERNEL * MAX_CH
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [6:0]  cmd,
  input  logic [31:0] inp0,
  input  logic [31:0] inp1,
  output logic [31:0] ret,
  output logic        output_buffer_valid
);

  localparam int AW = (BUF_DEPTH > 1) ? $clog2(BUF_DEPTH) : 1;
  localparam int IW = $clog2(2 * BUF_DEPTH + 2 * LANES) + 1;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DRAIN
  } state_t;

  state_t state;

  logic [7:0] in_buf [BUF_DEPTH];
  logic [7:0] w_buf  [BUF_DEPTH];

  logic signed [31:0] input_offset;
  logic signed [31:0] bias;
  logic [31:0] kernel_len;
  logic [31:0] input_depth;
  logic [31:0] start_filter_x;

  logic [ACC_WIDTH-1:0] acc;
  logic                 err;
  logic [IW-1:0]        i_cnt;
  logic [IW-1:0]        n_len;
  logic [IW-1:0]        base;

  logic [ACC_WIDTH-1:0] prod_q [LANES];
  logic [ACC_WIDTH-1:0] prod_d [LANES];
  logic [ACC_WIDTH-1:0] prod_sum;

  logic [IW-1:0] lane_e   [LANES];
  logic [IW-1:0] lane_idx [LANES];
  logic signed [ACC_WIDTH-1:0] lane_x [LANES];
  logic signed [ACC_WIDTH-1:0] lane_w [LANES];
  logic signed [ACC_WIDTH-1:0] off_ext;

  logic        busy;
  logic        done;
  logic        is_wr_buf;
  logic        is_wr_par;
  logic        start_ok;
  logic [32:0] wr_addr [4];

  assign done = (state == IDLE);
  assign busy = !done;

  assign is_wr_buf = cmd inside {7'd10, 7'd11, 7'd12, 7'd13};
  assign is_wr_par = cmd inside {7'd20, 7'd21, 7'd25, 7'd26, 7'd44};

  assign start_ok = (kernel_len >= 32'd1)
                 && (kernel_len <= 32'(MAX_KERNEL))
                 && (input_depth >= 32'd1)
                 && (input_depth <= 32'(MAX_CH))
                 && (start_filter_x < kernel_len);

  assign off_ext = ACC_WIDTH'(input_offset);

  always_comb begin
    for (int k = 0; k < 4; k++) begin
      wr_addr[k] = {1'b0, inp0} + 33'(k);
    end
  end

  // Buffers carry no reset; out-of-range lanes drop individually.
  always_ff @(posedge clk) begin
    if (!reset && !busy && is_wr_buf) begin
      for (int k = 0; k < 4; k++) begin
        if ((k == 0 || cmd[2]) && wr_addr[k] < 33'(BUF_DEPTH)) begin
          if (cmd[0]) begin
            w_buf[wr_addr[k][AW-1:0]] <= inp1[8*k +: 8];
          end else begin
            in_buf[wr_addr[k][AW-1:0]] <= inp1[8*k +: 8];
          end
        end
      end
    end
  end

  // Rotated window index: e < N and base < N, so one wrap suffices.
  always_comb begin
    for (int j = 0; j < LANES; j++) begin
      lane_e[j]   = i_cnt + IW'(j);
      lane_idx[j] = lane_e[j] + base;
      if (lane_idx[j] >= n_len) begin
        lane_idx[j] = lane_idx[j] - n_len;
      end
      lane_x[j] = ACC_WIDTH'($signed(in_buf[lane_idx[j][AW-1:0]]));
      lane_w[j] = ACC_WIDTH'($signed(w_buf[lane_e[j][AW-1:0]]));
      prod_d[j] = '0;
      if (lane_e[j] < n_len) begin
        prod_d[j] = lane_w[j] * (lane_x[j] + off_ext);
      end
    end
  end

  always_comb begin
    prod_sum = '0;
    for (int j = 0; j < LANES; j++) begin
      prod_sum = prod_sum + prod_q[j];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state               <= IDLE;
      ret                 <= '0;
      output_buffer_valid <= 1'b1;
      acc                 <= '0;
      err                 <= 1'b0;
      input_offset        <= '0;
      bias                <= '0;
      kernel_len          <= 32'd1;
      input_depth         <= 32'd1;
      start_filter_x      <= '0;
      i_cnt               <= '0;
      n_len               <= '0;
      base                <= '0;
      for (int j = 0; j < LANES; j++) begin
        prod_q[j] <= '0;
      end
    end else begin
      output_buffer_valid <= 1'b1;
      ret <= '0;

      unique case (state)
        RUN: begin
          for (int j = 0; j < LANES; j++) begin
            prod_q[j] <= prod_d[j];
          end
          if (i_cnt != '0) begin
            acc <= acc + prod_sum;
          end
          i_cnt <= i_cnt + IW'(LANES);
          if (i_cnt + IW'(LANES) >= n_len) begin
            state <= DRAIN;
          end
        end
        DRAIN: begin
          acc   <= acc + prod_sum;
          state <= IDLE;
        end
        default: ;
      endcase

      unique case (cmd)
        7'd0: begin
          state <= IDLE;
          acc   <= '0;
          err   <= 1'b0;
        end
        7'd10, 7'd11, 7'd12, 7'd13: begin
          if (busy) err <= 1'b1;
        end
        7'd20, 7'd21, 7'd25, 7'd26, 7'd44: begin
          if (busy) begin
            err <= 1'b1;
          end else begin
            unique case (1'b1)
              cmd == 7'd20: input_offset   <= inp1;
              cmd == 7'd21: bias           <= inp1;
              cmd == 7'd25: kernel_len     <= inp1;
              cmd == 7'd26: input_depth    <= inp1;
              default:      start_filter_x <= inp1;
            endcase
          end
        end
        7'd41: begin
          if (busy || !start_ok) begin
            err <= 1'b1;
          end else begin
            state <= RUN;
            acc   <= ACC_WIDTH'(bias);
            i_cnt <= '0;
            n_len <= IW'(kernel_len * input_depth);
            base  <= IW'(start_filter_x * input_depth);
          end
        end
        7'd43: ret <= acc[31:0];
        7'd45: ret <= {29'b0, err, busy, done};
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_conv1d_mac_pipe.sv
// tb_conv1d_mac_pipe: directed and randomized checks of the
// conv1d engine against a plain-arithmetic reference model.
module tb_conv1d_mac_pipe;

  localparam int LANES     = 8;
  localparam int BUF_DEPTH = 1024;
  localparam logic [6:0] NOP = 7'd127;

  logic        clk = 1'b0;
  logic        reset;
  logic [6:0]  cmd;
  logic [31:0] inp0;
  logic [31:0] inp1;
  logic [31:0] ret;
  logic        obv;

  always #5 clk = ~clk;

  conv1d_mac_pipe #(.LANES(LANES)) dut (
    .clk                 (clk),
    .reset               (reset),
    .cmd                 (cmd),
    .inp0                (inp0),
    .inp1                (inp1),
    .ret                 (ret),
    .output_buffer_valid (obv)
  );

  int errors = 0;
  int checks = 0;

  logic signed [7:0] xm [BUF_DEPTH];
  logic signed [7:0] wm [BUF_DEPTH];
  int p_kl   = 1;
  int p_dep  = 1;
  int p_sfx  = 0;
  int p_off  = 0;
  int p_bias = 0;

  // Drive one command for one cycle; ret is valid on return.
  task automatic issue(input logic [6:0] c,
                       input logic [31:0] a,
                       input logic [31:0] b);
    cmd  = c;
    inp0 = a;
    inp1 = b;
    @(posedge clk);
    #1;
    cmd  = NOP;
    inp0 = '0;
    inp1 = '0;
  endtask

  task automatic wr1(input bit is_w, input int a, input logic [7:0] v);
    issue(is_w ? 7'd11 : 7'd10, a, {24'b0, v});
    if (a < BUF_DEPTH) begin
      if (is_w) wm[a] = v;
      else xm[a] = v;
    end
  endtask

  task automatic wr4(input bit is_w, input int a, input logic [31:0] v);
    issue(is_w ? 7'd13 : 7'd12, a, v);
    for (int k = 0; k < 4; k++) begin
      if (a + k < BUF_DEPTH) begin
        if (is_w) wm[a+k] = v[8*k +: 8];
        else xm[a+k] = v[8*k +: 8];
      end
    end
  endtask

  task automatic set_params(input int kl, input int dep, input int sfx,
                            input int off, input int bias);
    issue(7'd25, 0, kl);
    issue(7'd26, 0, dep);
    issue(7'd44, 0, sfx);
    issue(7'd20, 0, off);
    issue(7'd21, 0, bias);
    p_kl = kl;
    p_dep = dep;
    p_sfx = sfx;
    p_off = off;
    p_bias = bias;
  endtask

  function automatic int ref_acc();
    int n;
    int s;
    n = p_kl * p_dep;
    s = p_bias;
    for (int i = 0; i < n; i++) begin
      s += int'(wm[i]) * (int'(xm[(i + p_sfx * p_dep) % n]) + p_off);
    end
    return s;
  endfunction

  function automatic int exp_busy();
    int n;
    n = p_kl * p_dep;
    return (n + LANES - 1) / LANES + 1;
  endfunction

  // Start, count busy status cycles (bounded), then read acc.
  task automatic run_job(output int nbusy, output logic [31:0] res);
    issue(7'd41, 0, 0);
    nbusy = 0;
    for (int t = 0; t < 400; t++) begin
      issue(7'd45, 0, 0);
      if (ret[1]) nbusy++;
      else break;
    end
    issue(7'd43, 0, 0);
    res = ret;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    cmd = NOP;
    inp0 = '0;
    inp1 = '0;
    repeat (2) @(posedge clk);
    #1;
    issue(7'd43, 0, 0);
    checks++;
    if (ret !== 32'd0) begin
      errors++;
      $display("FAIL reset_ret: got %0h want 0", ret);
    end
    checks++;
    if (obv !== 1'b1) begin
      errors++;
      $display("FAIL reset_obv: got %b want 1", obv);
    end
    reset = 1'b0;
    issue(7'd45, 0, 0);
    checks++;
    if (ret !== 32'd1) begin
      errors++;
      $display("FAIL reset_status: got %0h want 1", ret);
    end
    issue(7'd43, 0, 0);
    checks++;
    if (ret !== 32'd0) begin
      errors++;
      $display("FAIL reset_acc: got %0h want 0", ret);
    end
  endtask

  task automatic test_basic_sum();
    int nb;
    logic [31:0] r;
    for (int i = 0; i < 16; i++) begin
      wr1(1'b0, i, 8'(i));
      wr1(1'b1, i, 8'd1);
    end
    set_params(8, 2, 0, 0, 0);
    run_job(nb, r);
    checks++;
    if (nb != 3) begin
      errors++;
      $display("FAIL basic_busy: got %0d want 3", nb);
    end
    checks++;
    if (r !== 32'd120) begin
      errors++;
      $display("FAIL basic_sum: got %0d want 120", r);
    end
  endtask

  task automatic test_offset_bias();
    int nb;
    logic [31:0] r;
    for (int a = 0; a < 32; a += 4) begin
      wr4(1'b0, a, 32'h8080_8080);
      wr4(1'b1, a, 32'h0202_0202);
    end
    set_params(8, 4, 0, 128, 100);
    run_job(nb, r);
    checks++;
    if (nb != 5) begin
      errors++;
      $display("FAIL offset_busy: got %0d want 5", nb);
    end
    checks++;
    if (r !== 32'd100) begin
      errors++;
      $display("FAIL offset_bias: got %0d want 100", r);
    end
  endtask

  task automatic test_wrap();
    int nb;
    logic [31:0] r;
    for (int i = 0; i < 4; i++) begin
      wr1(1'b0, i, 8'(10 * (i + 1)));
      wr1(1'b1, i, (i == 0) ? 8'd1 : 8'd0);
    end
    set_params(4, 1, 3, 0, 0);
    run_job(nb, r);
    checks++;
    if (r !== 32'd40) begin
      errors++;
      $display("FAIL wrap_sfx3: got %0d want 40", r);
    end
    checks++;
    if (nb != 2) begin
      errors++;
      $display("FAIL wrap_busy: got %0d want 2", nb);
    end
    set_params(4, 1, 1, 0, 0);
    run_job(nb, r);
    checks++;
    if (r !== 32'd20) begin
      errors++;
      $display("FAIL wrap_sfx1: got %0d want 20", r);
    end
  endtask

  task automatic test_lane_mask();
    int nb;
    logic [31:0] r;
    for (int i = 0; i < 16; i++) begin
      wr1(1'b0, i, (i < 9) ? 8'd1 : 8'd127);
      wr1(1'b1, i, (i < 9) ? 8'd1 : 8'd127);
    end
    set_params(3, 3, 0, 0, 0);
    run_job(nb, r);
    checks++;
    if (nb != 3) begin
      errors++;
      $display("FAIL mask_busy: got %0d want 3", nb);
    end
    checks++;
    if (r !== 32'd9) begin
      errors++;
      $display("FAIL mask_sum: got %0d want 9", r);
    end
  endtask

  task automatic test_errors();
    int nb;
    logic [31:0] r;
    set_params(3, 3, 3, 0, 0);
    issue(7'd41, 0, 0);
    issue(7'd45, 0, 0);
    checks++;
    if (ret !== 32'b101) begin
      errors++;
      $display("FAIL err_bad_sfx: status %0b want 101", ret);
    end
    issue(7'd43, 0, 0);
    checks++;
    if (ret !== 32'd9) begin
      errors++;
      $display("FAIL err_acc_kept: got %0d want 9", ret);
    end
    issue(7'd0, 0, 0);
    set_params(8, 2, 0, 0, 0);
    issue(7'd41, 0, 0);
    issue(7'd41, 0, 0);
    issue(7'd10, 0, 99);
    nb = 0;
    for (int t = 0; t < 50; t++) begin
      issue(7'd45, 0, 0);
      if (ret[1]) nb++;
      else break;
    end
    checks++;
    if (ret !== 32'b101) begin
      errors++;
      $display("FAIL err_run_status: status %0b want 101", ret);
    end
    issue(7'd43, 0, 0);
    r = ret;
    checks++;
    if (r !== 32'(ref_acc())) begin
      errors++;
      $display("FAIL err_run_result: got %0d want %0d", r, ref_acc());
    end
  endtask

  task automatic test_abort();
    issue(7'd41, 0, 0);
    issue(NOP, 0, 0);
    reset = 1'b1;
    issue(7'd43, 0, 0);
    checks++;
    if (ret !== 32'd0) begin
      errors++;
      $display("FAIL abort_ret_in_reset: got %0h want 0", ret);
    end
    reset = 1'b0;
    p_kl = 1;
    p_dep = 1;
    p_sfx = 0;
    p_off = 0;
    p_bias = 0;
    issue(7'd45, 0, 0);
    checks++;
    if (ret !== 32'b001) begin
      errors++;
      $display("FAIL abort_rst_status: got %0b want 001", ret);
    end
    issue(7'd43, 0, 0);
    checks++;
    if (ret !== 32'd0) begin
      errors++;
      $display("FAIL abort_rst_acc: got %0h want 0", ret);
    end
    set_params(8, 2, 0, 0, 55);
    issue(7'd41, 0, 0);
    issue(7'd41, 0, 0);
    issue(7'd0, 0, 0);
    issue(7'd45, 0, 0);
    checks++;
    if (ret !== 32'b001) begin
      errors++;
      $display("FAIL abort_cmd0_status: got %0b want 001", ret);
    end
    issue(7'd43, 0, 0);
    checks++;
    if (ret !== 32'd0) begin
      errors++;
      $display("FAIL abort_cmd0_acc: got %0h want 0", ret);
    end
  endtask

  task automatic test_boundary();
    int nb;
    int eb;
    logic [31:0] r;
    for (int a = 0; a < BUF_DEPTH; a += 4) begin
      wr4(1'b0, a, $urandom);
      wr4(1'b1, a, $urandom);
    end
    wr4(1'b0, BUF_DEPTH - 2, $urandom);
    wr4(1'b1, BUF_DEPTH - 2, $urandom);
    wr1(1'b0, BUF_DEPTH, 8'h5a);
    wr1(1'b1, BUF_DEPTH, 8'h5a);
    set_params(8, 128, $urandom_range(0, 7),
               int'($urandom_range(0, 511)) - 256, $urandom);
    eb = exp_busy();
    run_job(nb, r);
    checks++;
    if (nb != eb) begin
      errors++;
      $display("FAIL full_busy: got %0d want %0d", nb, eb);
    end
    checks++;
    if (r !== 32'(ref_acc())) begin
      errors++;
      $display("FAIL full_result: got %0h want %0h", r, ref_acc());
    end
  endtask

  task automatic test_random();
    int nb;
    int eb;
    int n;
    int kl;
    logic [31:0] r;
    for (int it = 0; it < 8; it++) begin
      kl = $urandom_range(1, 8);
      n = kl * $urandom_range(1, 16);
      for (int a = 0; a < n; a += 4) begin
        if ($urandom_range(0, 1) == 1) begin
          wr4(1'b0, a, $urandom);
          wr4(1'b1, a, $urandom);
        end else begin
          for (int k = 0; k < 4; k++) begin
            wr1(1'b0, a + k, 8'($urandom));
            wr1(1'b1, a + k, 8'($urandom));
          end
        end
      end
      set_params(kl, n / kl, $urandom_range(0, kl - 1),
                 ($urandom_range(0, 3) == 0) ? int'($urandom)
                   : int'($urandom_range(0, 511)) - 256,
                 $urandom);
      eb = exp_busy();
      run_job(nb, r);
      checks++;
      if (nb != eb) begin
        errors++;
        $display("FAIL rand_busy[%0d]: got %0d want %0d", it, nb, eb);
      end
      checks++;
      if (r !== 32'(ref_acc())) begin
        errors++;
        $display("FAIL rand_result[%0d]: got %0h want %0h",
                 it, r, ref_acc());
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic_sum();
    test_offset_bias();
    test_wrap();
    test_lane_mask();
    test_errors();
    test_abort();
    test_boundary();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
